// File: rtl/seg_text_engine.sv
`default_nettype none
// ============================================================================
// Module      : seg_text_engine
// Description : Programmable seven-segment text engine. Generates one 6-bit
//               character code per tube in static, scrolling or
//               label-plus-decimal modes, with per-tube blinking and a
//               sequential binary-to-BCD (double dabble) converter.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_text_engine #(
  parameter int NUM_DIGITS   = 8,
  parameter int MSG_DEPTH    = 16,
  parameter int VAL_W        = 10,
  parameter int NUM_DEC      = 4,
  parameter int SCROLL_TICKS = 25_000_000,
  parameter int BLINK_TICKS  = 12_500_000
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [1:0]                            mode,
  input  logic                                  msg_we,
  input  logic [$clog2(MSG_DEPTH)-1:0]          msg_addr,
  input  logic [5:0]                            msg_data,
  input  logic [$clog2(MSG_DEPTH):0]            msg_len,
  input  logic [VAL_W-1:0]                      value,
  input  logic                                  value_load,
  input  logic                                  blink_en,
  input  logic [NUM_DIGITS-1:0]                 blink_mask,
  output logic [6*NUM_DIGITS-1:0]               tube_codes,
  output logic                                  conv_busy,
  output logic [$clog2(MSG_DEPTH+NUM_DIGITS):0] scroll_pos
);

  localparam int c_aw   = $clog2(MSG_DEPTH);
  localparam int c_lw   = c_aw + 1;
  localparam int c_spw  = $clog2(MSG_DEPTH + NUM_DIGITS) + 1;
  localparam int c_scw  = $clog2(SCROLL_TICKS + 1);
  localparam int c_bkw  = $clog2(BLINK_TICKS + 1);
  localparam int c_cw   = $clog2(VAL_W + 1);
  // Enough BCD digits to hold 2^VAL_W-1, plus one spare for saturation detect.
  localparam int c_full = (VAL_W * 3) / 10 + 2;
  localparam int c_wdig = (c_full > NUM_DEC) ? c_full : NUM_DEC + 1;
  localparam logic [5:0] c_blank = 6'd63;

  logic [5:0]            r_msg [MSG_DEPTH];
  logic                  r_we;
  logic [c_aw-1:0]       r_waddr;
  logic [5:0]            r_wdata;
  logic [c_lw-1:0]       w_len;
  logic [c_spw-1:0]      w_total;
  logic [1:0]            r_mode_q;
  logic [c_lw-1:0]       r_len_q;
  logic [c_scw-1:0]      r_scroll_cnt;
  logic [c_spw-1:0]      r_scroll_pos;
  logic [c_bkw-1:0]      r_blink_cnt;
  logic                  r_phase;
  logic                  r_busy;
  logic [c_cw-1:0]       r_cnt;
  logic [VAL_W-1:0]      r_bin;
  logic [4*c_wdig-1:0]   r_work;
  logic [4*NUM_DEC-1:0]  r_bcd;
  logic [4*c_wdig-1:0]   w_adj;
  logic [4*c_wdig-1:0]   w_shift;
  logic                  w_ovf;
  logic [4*NUM_DEC-1:0]  w_nines;
  logic [4*NUM_DIGITS-1:0] w_bcd_ext;
  logic [6*NUM_DIGITS-1:0] w_next;
  logic [6*NUM_DIGITS-1:0] r_tubes;

  assign w_len      = (msg_len > c_lw'(MSG_DEPTH)) ? c_lw'(MSG_DEPTH) : msg_len;
  assign w_total    = c_spw'(w_len) + c_spw'(NUM_DIGITS);
  assign w_bcd_ext  = (4*NUM_DIGITS)'(r_bcd);
  assign tube_codes = r_tubes;
  assign conv_busy  = r_busy;
  assign scroll_pos = r_scroll_pos;

  // Write port is staged one cycle so a write reaches the tubes two edges later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      for (int i = 0; i < MSG_DEPTH; i++) r_msg[i] <= c_blank;
    end else begin
      r_we    <= msg_we;
      r_waddr <= msg_addr;
      r_wdata <= msg_data;
      if (r_we) r_msg[r_waddr] <= r_wdata;
    end
  end

  // Scroll offset: restarts on mode/length change, held at 0 for an empty message.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode_q     <= 2'd0;
      r_len_q      <= '0;
      r_scroll_cnt <= '0;
      r_scroll_pos <= '0;
    end else begin
      r_mode_q <= mode;
      r_len_q  <= msg_len;
      if (mode != r_mode_q || msg_len != r_len_q || w_len == '0) begin
        r_scroll_cnt <= '0;
        r_scroll_pos <= '0;
      end else if (r_scroll_cnt == c_scw'(SCROLL_TICKS - 1)) begin
        r_scroll_cnt <= '0;
        r_scroll_pos <= (r_scroll_pos == w_total - c_spw'(1)) ? '0 : r_scroll_pos + c_spw'(1);
      end else begin
        r_scroll_cnt <= r_scroll_cnt + c_scw'(1);
      end
    end
  end

  // Blink phase generator; disabled means counter cleared and phase visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (!blink_en) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (r_blink_cnt == c_bkw'(BLINK_TICKS - 1)) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + c_bkw'(1);
    end
  end

  // One double-dabble step: add 3 to every digit >= 5, then shift in next bit.
  always_comb begin
    w_adj   = r_work;
    w_nines = '0;
    for (int d = 0; d < c_wdig; d++) begin
      if (r_work[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_work[4*d +: 4] + 4'd3;
    end
    for (int d = 0; d < NUM_DEC; d++) w_nines[4*d +: 4] = 4'd9;
    w_shift = {w_adj[4*c_wdig-2:0], r_bin[VAL_W-1]};
    w_ovf   = |w_shift[4*c_wdig-1:4*NUM_DEC];
  end

  // Converter: VAL_W busy cycles, result register updated only when busy falls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_bin  <= '0;
      r_work <= '0;
      r_bcd  <= '0;
    end else if (r_busy) begin
      r_bin  <= r_bin << 1;
      r_work <= w_shift;
      r_cnt  <= r_cnt + c_cw'(1);
      if (r_cnt == c_cw'(VAL_W - 1)) begin
        r_busy <= 1'b0;
        r_bcd  <= w_ovf ? w_nines : w_shift[4*NUM_DEC-1:0];
      end
    end else if (value_load) begin
      r_bin  <= value;
      r_work <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end
  end

  // Per-tube character selection, walking tubes left to right for zero blanking.
  always_comb begin : p_display
    logic [c_spw-1:0] w_idx;
    logic [5:0]       w_stat;
    logic [5:0]       w_scr;
    logic [5:0]       w_num;
    logic [5:0]       w_ch;
    logic [3:0]       w_dig;
    logic             w_lead;
    int               k;
    w_next = '0;
    w_lead = 1'b1;
    w_idx  = '0;
    w_stat = c_blank;
    w_scr  = c_blank;
    w_num  = c_blank;
    w_ch   = c_blank;
    w_dig  = 4'd0;
    k      = 0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      k      = NUM_DIGITS - 1 - i;
      w_stat = (c_lw'(k) < w_len) ? r_msg[c_aw'(k)] : c_blank;
      w_idx  = r_scroll_pos + c_spw'(k);
      if (w_idx >= w_total) w_idx = w_idx - w_total;
      w_scr  = (w_idx < c_spw'(w_len)) ? r_msg[w_idx[c_aw-1:0]] : c_blank;
      w_dig  = w_bcd_ext[4*i +: 4];
      w_num  = c_blank;
      if (i < NUM_DEC) begin
        if (w_lead && w_dig == 4'd0 && i != 0) begin
          w_num = c_blank;
        end else begin
          w_lead = 1'b0;
          w_num  = {2'b00, w_dig};
        end
      end
      case (mode)
        2'd0:    w_ch = w_stat;
        2'd1:    w_ch = w_scr;
        2'd2:    w_ch = (i < NUM_DEC) ? w_num : w_stat;
        default: w_ch = c_blank;
      endcase
      // Dropping blink_en must restore the tube on the very next edge.
      if (blink_en && !r_phase && blink_mask[i]) w_ch = c_blank;
      w_next[6*i +: 6] = w_ch;
    end
  end

  // Registered tube outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_tubes <= '1;
    else       r_tubes <= w_next;
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_text_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_text_engine
// Description : Self-checking bench for seg_text_engine using an expected-value
//               queue; a second small instance covers BCD saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_text_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic        msg_we;
  logic [3:0]  msg_addr;
  logic [5:0]  msg_data;
  logic [4:0]  msg_len;
  logic [9:0]  value;
  logic        value_load;
  logic        blink_en;
  logic [7:0]  blink_mask;
  logic [47:0] tube_codes;
  logic        conv_busy;
  logic [5:0]  scroll_pos;
  logic [23:0] s_tubes;
  logic        s_busy;
  logic [5:0]  s_pos;

  int total = 0;
  int bad   = 0;
  logic [47:0] exp_q [$];
  logic [23:0] sexp_q [$];

  always #5 clk = ~clk;

  seg_text_engine #(
    .NUM_DIGITS(8), .MSG_DEPTH(16), .VAL_W(10), .NUM_DEC(4),
    .SCROLL_TICKS(4), .BLINK_TICKS(3)
  ) u_dut (
    .clk(clk), .reset(reset), .mode(mode), .msg_we(msg_we), .msg_addr(msg_addr),
    .msg_data(msg_data), .msg_len(msg_len), .value(value), .value_load(value_load),
    .blink_en(blink_en), .blink_mask(blink_mask), .tube_codes(tube_codes),
    .conv_busy(conv_busy), .scroll_pos(scroll_pos)
  );

  seg_text_engine #(
    .NUM_DIGITS(4), .MSG_DEPTH(16), .VAL_W(10), .NUM_DEC(2),
    .SCROLL_TICKS(4), .BLINK_TICKS(3)
  ) u_sat (
    .clk(clk), .reset(reset), .mode(mode), .msg_we(msg_we), .msg_addr(msg_addr),
    .msg_data(msg_data), .msg_len(msg_len), .value(value), .value_load(value_load),
    .blink_en(1'b0), .blink_mask(4'b0000), .tube_codes(s_tubes),
    .conv_busy(s_busy), .scroll_pos(s_pos)
  );

  function automatic logic [47:0] lr(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {6'(a0), 6'(a1), 6'(a2), 6'(a3), 6'(a4), 6'(a5), 6'(a6), 6'(a7)};
  endfunction

  function automatic logic [23:0] lr4(input int a0, a1, a2, a3);
    return {6'(a0), 6'(a1), 6'(a2), 6'(a3)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    msg_addr = 4'(a);
    msg_data = 6'(d);
    msg_we   = 1'b1;
    step();
    msg_we   = 1'b0;
  endtask

  task automatic test_reset();
    logic [47:0] e;
    reset = 1'b1; mode = 2'd0; msg_we = 1'b0; msg_addr = '0; msg_data = '0;
    msg_len = 5'd0; value = '0; value_load = 1'b0; blink_en = 1'b0; blink_mask = '0;
    step(); step();
    exp_q.push_back(lr(63, 63, 63, 63, 63, 63, 63, 63));
    e = exp_q.pop_front();
    total++;
    if (tube_codes !== e) begin bad++; $display("FAIL reset_tubes got=%h want=%h", tube_codes, e); end
    total++;
    if (scroll_pos !== 6'd0 || conv_busy !== 1'b0) begin
      bad++; $display("FAIL reset_state pos=%0d busy=%0b want 0/0", scroll_pos, conv_busy);
    end
    reset = 1'b0;
    step();
    exp_q.push_back(lr(63, 63, 63, 63, 63, 63, 63, 63));
    e = exp_q.pop_front();
    total++;
    if (tube_codes !== e) begin bad++; $display("FAIL post_reset_tubes got=%h want=%h", tube_codes, e); end
  endtask

  task automatic test_static();
    logic [47:0] e;
    msg_len = 5'd5; mode = 2'd0;
    wr(0, 21); wr(1, 14); wr(2, 10); wr(3, 27); wr(4, 23);
    exp_q.push_back(lr(21, 14, 10, 63, 63, 63, 63, 63));
    exp_q.push_back(lr(21, 14, 10, 27, 63, 63, 63, 63));
    exp_q.push_back(lr(21, 14, 10, 27, 23, 63, 63, 63));
    for (int n = 0; n < 3; n++) begin
      if (n > 0) step();
      e = exp_q.pop_front();
      total++;
      if (tube_codes !== e) begin bad++; $display("FAIL static_t+%0d got=%h want=%h", n, tube_codes, e); end
    end
  endtask

  task automatic test_scroll();
    int p;
    mode = 2'd1;
    for (int n = 0; n < 56; n++) begin
      step();
      p = (n / 4) % 13;
      total++;
      if (scroll_pos !== 6'(p)) begin bad++; $display("FAIL scroll_pos n=%0d got=%0d want=%0d", n, scroll_pos, p); end
      if (n == 13) begin
        total++;
        if (tube_codes !== lr(27, 23, 63, 63, 63, 63, 63, 63)) begin
          bad++; $display("FAIL scroll_pos3 got=%h want=%h", tube_codes, lr(27, 23, 63, 63, 63, 63, 63, 63));
        end
      end
      if (n == 49) begin
        total++;
        if (tube_codes[47:42] !== 6'd63 || tube_codes[41:36] !== 6'd21) begin
          bad++; $display("FAIL scroll_pos12 got=%0d,%0d want=63,21", tube_codes[47:42], tube_codes[41:36]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    while (scroll_pos !== 6'd5 && guard < 80) begin step(); guard++; end
    total++;
    if (scroll_pos !== 6'd5) begin bad++; $display("FAIL reach_pos5 got=%0d want=5", scroll_pos); end
    #2; reset = 1'b1; #1;
    total++;
    if (scroll_pos !== 6'd0 || tube_codes !== {48{1'b1}}) begin
      bad++; $display("FAIL async_reset pos=%0d tubes=%h want 0 and all 63", scroll_pos, tube_codes);
    end
    #1; reset = 1'b0; mode = 2'd0;
    for (int n = 0; n < 3; n++) begin
      step();
      total++;
      if (tube_codes !== {48{1'b1}}) begin bad++; $display("FAIL empty_static got=%h want all 63", tube_codes); end
    end
  endtask

  task automatic run_conv(input int v, input logic [47:0] old_e, input logic [47:0] new_e,
                          input logic [23:0] new_s, input logic poke);
    logic [47:0] e;
    logic [23:0] se;
    int cnt = 0;
    exp_q.push_back(old_e);
    exp_q.push_back(new_e);
    sexp_q.push_back(new_s);
    value = 10'(v); value_load = 1'b1;
    step();
    value_load = 1'b0;
    for (int i = 0; i < 30 && conv_busy; i++) begin
      cnt++;
      if (poke && i == 3) begin value = 10'd555; value_load = 1'b1; end
      step();
      value_load = 1'b0;
    end
    total++;
    if (cnt != 10) begin bad++; $display("FAIL busy_len v=%0d got=%0d want=10", v, cnt); end
    e = exp_q.pop_front();
    total++;
    if (tube_codes !== e) begin bad++; $display("FAIL conv_old v=%0d got=%h want=%h", v, tube_codes, e); end
    step();
    e = exp_q.pop_front();
    total++;
    if (tube_codes !== e) begin bad++; $display("FAIL conv_new v=%0d got=%h want=%h", v, tube_codes, e); end
    se = sexp_q.pop_front();
    total++;
    if (s_tubes !== se) begin bad++; $display("FAIL sat_dut v=%0d got=%h want=%h", v, s_tubes, se); end
  endtask

  task automatic test_number();
    msg_len = 5'd4; mode = 2'd2;
    wr(0, 30); wr(1, 28); wr(2, 14); wr(3, 27);
    step(); step();
    total++;
    if (tube_codes !== lr(30, 28, 14, 27, 63, 63, 63, 0)) begin
      bad++; $display("FAIL number_init got=%h want=%h", tube_codes, lr(30, 28, 14, 27, 63, 63, 63, 0));
    end
    run_conv(1023, lr(30, 28, 14, 27, 63, 63, 63, 0), lr(30, 28, 14, 27, 1, 0, 2, 3),
             lr4(30, 28, 9, 9), 1'b0);
    run_conv(7, lr(30, 28, 14, 27, 1, 0, 2, 3), lr(30, 28, 14, 27, 63, 63, 63, 7),
             lr4(30, 28, 63, 7), 1'b1);
  endtask

  task automatic test_blink();
    logic [47:0] e;
    logic off;
    mode = 2'd0; msg_len = 5'd5;
    wr(0, 21); wr(1, 14); wr(2, 10); wr(3, 27); wr(4, 23);
    step(); step();
    blink_mask = 8'b1001_0011; blink_en = 1'b1;
    for (int n = 0; n < 12; n++) begin
      off = (n >= 1) && (((n / 3) % 2) == 1);
      exp_q.push_back(off ? lr(63, 14, 10, 63, 23, 63, 63, 63) : lr(21, 14, 10, 27, 23, 63, 63, 63));
      step();
      e = exp_q.pop_front();
      total++;
      if (tube_codes !== e) begin bad++; $display("FAIL blink n=%0d got=%h want=%h", n, tube_codes, e); end
    end
    blink_en = 1'b0;
    exp_q.push_back(lr(21, 14, 10, 27, 23, 63, 63, 63));
    step();
    e = exp_q.pop_front();
    total++;
    if (tube_codes !== e) begin bad++; $display("FAIL blink_off got=%h want=%h", tube_codes, e); end
  endtask

  task automatic test_mode3_len0();
    mode = 2'd3;
    for (int n = 0; n < 8; n++) begin
      step();
      total++;
      if (tube_codes !== {48{1'b1}}) begin bad++; $display("FAIL mode3 n=%0d got=%h want all 63", n, tube_codes); end
      if (n == 4) begin
        total++;
        if (scroll_pos !== 6'd1) begin bad++; $display("FAIL mode3_counter got=%0d want=1", scroll_pos); end
      end
    end
    mode = 2'd1;
    for (int n = 0; n < 5; n++) begin
      step();
      if (n == 0 || n == 4) begin
        total++;
        if (scroll_pos !== 6'(n / 4)) begin bad++; $display("FAIL scroll_restart n=%0d got=%0d want=%0d", n, scroll_pos, n / 4); end
      end
    end
    msg_len = 5'd0;
    for (int n = 0; n < 10; n++) begin
      step();
      total++;
      if (scroll_pos !== 6'd0 || tube_codes !== {48{1'b1}}) begin
        bad++; $display("FAIL len0 n=%0d pos=%0d tubes=%h want 0 and all 63", n, scroll_pos, tube_codes);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_static();
    test_scroll();
    test_reset_mid();
    test_number();
    test_blink();
    test_mode3_len0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
